// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes, master FSM states and constants
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } mst_state_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input resp_t r);
        return r[1];
    endfunction

endpackage

// File: rtl/axi_lite_cfg_master.sv
// rtl/axi_lite_cfg_master.sv - single-outstanding AXI4-Lite initiator for command/response register access
module axi_lite_cfg_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 5,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        m00_axi_aclk,
    input  logic                        m00_axi_aresetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic                        timeout,
    output logic [AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                  m00_axi_awprot,
    output logic                        m00_axi_awvalid,
    input  logic                        m00_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                        m00_axi_wvalid,
    input  logic                        m00_axi_wready,
    input  logic [1:0]                  m00_axi_bresp,
    input  logic                        m00_axi_bvalid,
    output logic                        m00_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                  m00_axi_arprot,
    output logic                        m00_axi_arvalid,
    input  logic                        m00_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                  m00_axi_rresp,
    input  logic                        m00_axi_rvalid,
    output logic                        m00_axi_rready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mst_state_t                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic [CNT_W-1:0]            tmo_cnt;
    logic                        aw_done;
    logic                        w_done;
    logic                        busy;

    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = wstrb_q;
    assign m00_axi_awprot = AXI_PROT_DEFAULT;
    assign m00_axi_arprot = AXI_PROT_DEFAULT;

    // A channel counts as done once its valid has dropped or is being accepted this edge.
    assign aw_done = !m00_axi_awvalid || m00_axi_awready;
    assign w_done  = !m00_axi_wvalid  || m00_axi_wready;
    assign busy    = (state == ST_WRITE) || (state == ST_WRESP) ||
                     (state == ST_READ)  || (state == ST_RDATA);

    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            state           <= ST_IDLE;
            cmd_ready       <= 1'b0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_rdata       <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            tmo_cnt         <= '0;
            timeout         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        tmo_cnt   <= '0;
                        if (cmd_write) begin
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= ST_WRITE;
                        end else begin
                            m00_axi_arvalid <= 1'b1;
                            state           <= ST_READ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (m00_axi_awvalid && m00_axi_awready) m00_axi_awvalid <= 1'b0;
                    if (m00_axi_wvalid && m00_axi_wready)   m00_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m00_axi_bready <= 1'b1;
                        state          <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m00_axi_bvalid) begin
                        m00_axi_bready <= 1'b0;
                        rsp_rdata      <= '0;
                        rsp_err        <= resp_is_err(resp_t'(m00_axi_bresp));
                        rsp_valid      <= 1'b1;
                        state          <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m00_axi_rvalid) begin
                        m00_axi_rready <= 1'b0;
                        rsp_rdata      <= m00_axi_rdata;
                        rsp_err        <= resp_is_err(resp_t'(m00_axi_rresp));
                        rsp_valid      <= 1'b1;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // The transaction keeps waiting after timeout so the slave never sees a dropped valid.
            if (busy) begin
                if (tmo_cnt != CNT_W'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + CNT_W'(1);
                if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb/tb_axi_lite_cfg_master.sv - randomized self-checking bench with behavioural slave and reference model
module tb_axi_lite_cfg_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          timeout;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rvalid = 1'b0;
    logic          rready;

    axi_lite_cfg_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Per-transaction slave behaviour chosen by the stimulus
    int         g_aw_dly = 0, g_w_dly = 0, g_b_dly = 0, g_ar_dly = 0, g_r_dly = 0;
    logic [1:0] g_resp = 2'b00;

    // Reference model state
    logic [31:0] m_mem [8];
    logic [31:0] s_mem [8];
    bit          m_busy = 0, m_axi = 0, m_rspv = 0, m_timeout = 0;
    int          m_cnt = 0;
    bit          c_write = 0, c_err = 0;
    logic [AW-1:0] c_addr = '0;
    logic [31:0] c_wdata = '0, c_rdata = '0;
    logic [3:0]  c_strb = '0;

    // Slave state
    bit          s_aw_got = 0, s_w_got = 0, s_ar_got = 0;
    int          s_aw_age = 0, s_w_age = 0, s_ar_age = 0, s_b_age = 0, s_r_age = 0;
    logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;

    // Values seen at the previous negedge, i.e. what the last posedge sampled
    bit          p_aresetn = 0, p_accept = 0, p_write = 0, p_bfire = 0, p_rfire = 0, p_rsphs = 0;
    logic [AW-1:0] p_addr = '0, p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0, p_cwdata = '0;
    logic [3:0]  p_strb = '0, p_wstrb = '0;
    bit          p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_arvalid = 0, p_arready = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin m_mem[i] = '0; s_mem[i] = '0; end
        forever begin
            @(negedge clk);
            if (!p_aresetn) begin
                m_busy = 0; m_axi = 0; m_rspv = 0; m_timeout = 0; m_cnt = 0;
            end else begin
                if (p_accept) begin
                    m_busy = 1; m_axi = 1; m_cnt = 0;
                    c_write = p_write; c_addr = p_addr; c_wdata = p_cwdata; c_strb = p_strb;
                    c_err   = (g_resp == 2'd2) || (g_resp == 2'd3);
                    c_rdata = p_write ? 32'h0 : m_mem[p_addr[4:2]];
                end else if (m_axi) begin
                    m_cnt++;
                    if (m_cnt >= TO) m_timeout = 1;
                    if (p_bfire || p_rfire) begin
                        m_axi = 0; m_rspv = 1;
                        if (c_write) m_mem[c_addr[4:2]] = merge(m_mem[c_addr[4:2]], c_wdata, c_strb);
                    end
                end
                if (p_rsphs) begin m_rspv = 0; m_busy = 0; end
            end

            check("cmd_ready", {31'b0, cmd_ready}, {31'b0, p_aresetn && !m_busy});
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rspv});
            check("timeout", {31'b0, timeout}, {31'b0, m_timeout});
            if (m_rspv) begin
                check("rsp_rdata", rsp_rdata, c_rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, c_err});
            end
            if (!m_axi) begin
                check("axi_quiet", {27'b0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
            end else begin
                if (p_awvalid) check("awvalid_hs", {31'b0, awvalid}, {31'b0, !p_awready});
                if (p_awvalid && !p_awready) check("awaddr_stable", {27'b0, awaddr}, {27'b0, p_awaddr});
                if (p_wvalid) check("wvalid_hs", {31'b0, wvalid}, {31'b0, !p_wready});
                if (p_wvalid && !p_wready) check("wdata_stable", wdata ^ {28'b0, wstrb}, p_wdata ^ {28'b0, p_wstrb});
                if (p_arvalid) check("arvalid_hs", {31'b0, arvalid}, {31'b0, !p_arready});
                if (p_arvalid && !p_arready) check("araddr_stable", {27'b0, araddr}, {27'b0, p_araddr});
            end

            if (!aresetn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
                s_aw_age = 0; s_w_age = 0; s_ar_age = 0; s_b_age = 0; s_r_age = 0;
            end else begin
                if (p_bfire) begin
                    bvalid = 0; s_aw_got = 0; s_w_got = 0; s_b_age = 0;
                end else if (s_aw_got && s_w_got && !bvalid) begin
                    if (s_b_age >= g_b_dly) begin
                        bvalid = 1; bresp = g_resp;
                        s_mem[s_awaddr[4:2]] = merge(s_mem[s_awaddr[4:2]], s_wdata, s_wstrb);
                    end else s_b_age++;
                end
                if (p_rfire) begin
                    rvalid = 0; s_ar_got = 0; s_r_age = 0;
                end else if (s_ar_got && !rvalid) begin
                    if (s_r_age >= g_r_dly) begin
                        rvalid = 1; rresp = g_resp; rdata = s_mem[s_araddr[4:2]];
                    end else s_r_age++;
                end
                awready = 0;
                if (awvalid && !s_aw_got) begin
                    if (s_aw_age >= g_aw_dly) begin
                        awready = 1; s_aw_got = 1; s_aw_age = 0; s_awaddr = awaddr;
                        check("awaddr", {27'b0, awaddr}, {27'b0, c_addr});
                    end else s_aw_age++;
                end
                wready = 0;
                if (wvalid && !s_w_got) begin
                    if (s_w_age >= g_w_dly) begin
                        wready = 1; s_w_got = 1; s_w_age = 0; s_wdata = wdata; s_wstrb = wstrb;
                        check("wdata", wdata, c_wdata);
                        check("wstrb", {28'b0, wstrb}, {28'b0, c_strb});
                    end else s_w_age++;
                end
                arready = 0;
                if (arvalid && !s_ar_got) begin
                    if (s_ar_age >= g_ar_dly) begin
                        arready = 1; s_ar_got = 1; s_ar_age = 0; s_araddr = araddr;
                        check("araddr", {27'b0, araddr}, {27'b0, c_addr});
                    end else s_ar_age++;
                end
            end

            p_aresetn = aresetn;
            p_accept  = aresetn && cmd_valid && cmd_ready;
            p_write = cmd_write; p_addr = cmd_addr; p_cwdata = cmd_wdata; p_strb = cmd_wstrb;
            p_bfire = bvalid && bready; p_rfire = rvalid && rready; p_rsphs = rsp_valid && rsp_ready;
            p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
            p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        end
    end

    task automatic do_reset();
        aresetn = 0;
        repeat (3) @(posedge clk);
        #2 aresetn = 1;
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] resp);
        g_aw_dly = aw; g_w_dly = w; g_b_dly = b; g_ar_dly = ar; g_r_dly = r; g_resp = resp;
    endtask

    task automatic set_cmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) check("accept_budget", 32'h0, 32'h1);
        @(posedge clk);
        #2 cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er,
                            output int av_hi, output int wv_hi);
        bit got = 0;
        lat = 0; av_hi = 0; wv_hi = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (awvalid) av_hi++;
            if (wvalid) wv_hi++;
            if (rsp_valid) got = 1;
        end
        if (!got) check("rsp_budget", 32'h0, 32'h1);
        rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic finish_rsp(input int hold);
        @(posedge clk);
        #2;
        for (int i = 0; i < hold; i++) begin @(posedge clk); #2; end
        rsp_ready = 1;
        @(posedge clk);
        #2 rsp_ready = 0;
    endtask

    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, output int lat, output logic [31:0] rd, output logic er,
                       output int av_hi, output int wv_hi);
        set_cmd(wr, a, d, s);
        wait_accept();
        wait_rsp(lat, rd, er, av_hi, wv_hi);
        finish_rsp(hold);
    endtask

    initial begin
        int lat, av, wv;
        logic [31:0] rd;
        logic er;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        check("rst_valids", {27'b0, awvalid, wvalid, arvalid, rsp_valid, timeout}, 32'h0);
        check("rst_awaddr", {27'b0, awaddr}, 32'h0);
        @(posedge clk);
        #2 aresetn = 1;
        @(posedge clk);
        #2;

        set_slave(1, 4, 0, 0, 0, 2'd0);
        txn(1, 5'h00, 32'h1c1c1c1c, 4'hF, 0, lat, rd, er, av, wv);
        check("stag_err", {31'b0, er}, 32'h0);
        check("stag_aw_cycles", av, 2);
        check("stag_w_cycles", wv, 5);

        set_slave(0, 0, 0, 0, 0, 2'd0);
        txn(0, 5'h00, 32'h0, 4'h0, 0, lat, rd, er, av, wv);
        check("rb_data", rd, 32'h1c1c1c1c);
        check("rb_err", {31'b0, er}, 32'h0);
        check("rb_latency", lat, 3);

        set_slave(0, 0, 0, 0, 0, 2'd2);
        txn(1, 5'h14, 32'ha5a55a5a, 4'hF, 0, lat, rd, er, av, wv);
        check("slverr_err", {31'b0, er}, 32'h1);
        check("wr_latency", lat, 3);
        set_slave(0, 0, 0, 0, 0, 2'd3);
        txn(0, 5'h14, 32'h0, 4'h0, 0, lat, rd, er, av, wv);
        check("decerr_err", {31'b0, er}, 32'h1);
        check("decerr_data", rd, 32'ha5a55a5a);

        set_slave(0, 0, 0, 0, 0, 2'd0);
        set_cmd(0, 5'h00, 32'h0, 4'h0);
        wait_accept();
        wait_rsp(lat, rd, er, av, wv);
        @(posedge clk);
        #2 set_cmd(1, 5'h08, 32'h0badf00d, 4'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            check("bp_rdata", rsp_rdata, 32'h1c1c1c1c);
        end
        @(posedge clk);
        #2 rsp_ready = 1;
        @(posedge clk);
        #2 rsp_ready = 0;
        @(negedge clk);
        check("bp_ready_back", {31'b0, cmd_ready}, 32'h1);
        @(posedge clk);
        #2 cmd_valid = 0;
        wait_rsp(lat, rd, er, av, wv);
        finish_rsp(0);

        set_slave(50, 0, 0, 0, 0, 2'd0);
        set_cmd(1, 5'h04, 32'hdeadbeef, 4'hF);
        wait_accept();
        repeat (2) @(posedge clk);
        #2 aresetn = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_valids", {29'b0, awvalid, wvalid, rsp_valid}, 32'h0);
        @(posedge clk);
        #2 aresetn = 1;
        set_slave(0, 0, 0, 0, 0, 2'd0);
        txn(1, 5'h04, 32'h12345678, 4'hF, 0, lat, rd, er, av, wv);
        check("post_rst_err", {31'b0, er}, 32'h0);

        set_slave(0, 0, 0, 10, 0, 2'd0);
        set_cmd(0, 5'h04, 32'h0, 4'h0);
        wait_accept();
        repeat (8) @(negedge clk);
        check("tmo_before", {31'b0, timeout}, 32'h0);
        @(negedge clk);
        check("tmo_set", {30'b0, timeout, arvalid}, 32'h3);
        wait_rsp(lat, rd, er, av, wv);
        check("tmo_rdata", rd, 32'h12345678);
        finish_rsp(1);
        set_slave(0, 0, 0, 0, 0, 2'd0);
        txn(0, 5'h00, 32'h0, 4'h0, 0, lat, rd, er, av, wv);
        check("tmo_sticky", {31'b0, timeout}, 32'h1);
        aresetn = 0;
        @(posedge clk);
        @(negedge clk);
        check("tmo_cleared", {31'b0, timeout}, 32'h0);
        @(posedge clk);
        #2 aresetn = 1;

        for (int n = 0; n < 40; n++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom_range(0, 3)));
            txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 3), lat, rd, er, av, wv);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_cfg_master.md
Name: axi_lite_cfg_master

Overview:
- AXI4-Lite initiator that turns single-beat command requests into AXI-Lite write or read transactions toward a 5-bit-addressed register slave, such as the address-offset register block.
- Replaces behavioural testbench tasks with synthesizable logic, so on-FPGA control logic can program and read back offset registers.
- Exactly one outstanding transaction; a response is returned per command.

Parameters:
AXI_ADDR_WIDTH, 5, slave-side address width
AXI_DATA_WIDTH, 32, data width (multiple of 8)
TIMEOUT_CYCLES, 256, cycles in a transaction before the sticky timeout flag sets (>=2)

Ports:
m00_axi_aclk  in  1  clock
m00_axi_aresetn  in  1  reset; synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data
cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  BRESP/RRESP was SLVERR or DECERR
timeout  out  1  sticky; cleared only by reset
m00_axi_awaddr/awprot/awvalid/awready  AW channel (awprot driven 3'b000)
m00_axi_wdata/wstrb/wvalid/wready  W channel
m00_axi_bresp/bvalid/bready  B channel
m00_axi_araddr/arprot/arvalid/arready  AR channel (arprot driven 3'b000)
m00_axi_rdata/rresp/rvalid/rready  R channel

Behaviour:
- Reset (aresetn=0 at clock edge): state IDLE; all valid outputs, bready, rready, rsp_valid, rsp_err, timeout = 0; address/data registers = 0; cmd_ready = 0 during reset.
- Reset asserted mid-transaction aborts immediately with no response. Slave reset is shared, so no protocol violation results.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr, data and strb.
  - Write goes to WRITE, with awvalid=wvalid=1 from the next cycle.
  - Read goes to READ, with arvalid=1 from the next cycle.
- WRITE:
  - awvalid drops the cycle after the awvalid&awready handshake; wvalid drops the cycle after wvalid&wready. The two are tracked independently.
  - Either order, or simultaneous, is legal.
  - Once both handshakes are done, go to WRESP with bready=1.
- WRESP: on bvalid, capture bresp, drop bready, go to RESP.
- READ: on arvalid&arready, drop arvalid, set rready=1, go to RDATA.
- RDATA: on rvalid, capture rdata and rresp, drop rready, go to RESP.
- RESP:
  - rsp_valid=1 and rsp_err = resp[1].
  - Hold rsp_rdata and rsp_err stable until rsp_ready.
  - When rsp_ready is seen, return to IDLE with cmd_ready=1 on the next cycle.
- Valid signals never drop before their handshake (AXI rule). Address and data stay stable while valid is high.
- Minimum latency against a zero-wait slave:
  - Write: command accept to rsp_valid = 3 cycles.
  - Read: command accept to rsp_valid = 3 cycles.
- Timeout counter:
  - Cleared on command accept; increments every cycle in WRITE, WRESP, READ or RDATA; saturates.
  - When it reaches TIMEOUT_CYCLES, timeout is set (sticky).
  - The transaction is never abandoned; the block keeps waiting to stay protocol-legal.
- cmd_valid while busy is ignored (cmd_ready=0); the requester holds it.
- All outputs are registered; no combinational path from AXI inputs to AXI outputs.

Decomposition:
- Package axi_lite_pkg holds:
  - resp_t 2-bit enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Master FSM state enum.
  - Constant AXI_PROT_DEFAULT = 3'b000.
- No sub-module; the FSM and timeout counter fit in one module.

Test Plan:
- Write with staggered handshakes: after reset release, write addr 0x00, data 0x1c1c1c1c, strb 0xF. Slave raises awready 1 cycle after awvalid and wready 3 cycles later, then returns bresp OKAY. Expect:
  - awvalid falls after 1 cycle and wvalid falls after 3.
  - Exactly one rsp_valid, with rsp_err=0.
  - Register 0 reads 0x1c1c1c1c.
- Read-back: read addr 0x00 from a zero-wait slave. Expect rsp_rdata=0x1c1c1c1c and rsp_err=0, with rsp_valid exactly 3 cycles after command accept.
- Error response: write to addr 0x14 with slave bresp=SLVERR. Expect rsp_err=1. A following read with rresp=DECERR also gives rsp_err=1, and rdata is still returned.
- Back-pressure: hold rsp_ready=0 for 5 cycles and issue a second cmd_valid. Expect:
  - cmd_ready=0 and no AXI valid asserted during that time.
  - rsp_rdata stays stable.
  - The second command is accepted the cycle after rsp_ready returns.
- Reset mid-transaction: assert aresetn=0 while awvalid is high and awready=0. Expect all AXI valids and rsp_valid low at the next edge. After release, a fresh write completes normally.
- Timeout: TIMEOUT_CYCLES=8 with arready held at 0. Expect:
  - timeout rises after 8 cycles in READ while arvalid stays high.
  - Releasing arready completes the read normally.
  - timeout stays at 1 until reset.
